// File: rtl/shreg_ctrl_pkg.sv
// Shared types for the shift-register controller: operation codes and FSM states.
// Also used by the shift register bench so both sides agree on the op encoding.
package shreg_ctrl_pkg;

   typedef enum logic [2:0] {
      OP_CLEAR = 3'b000,
      OP_SHL   = 3'b001,
      OP_SHR   = 3'b010,
      OP_LOAD  = 3'b011,
      OP_ROL   = 3'b100,
      OP_ROR   = 3'b101,
      OP_ASL   = 3'b110,
      OP_ASR   = 3'b111
   } sr_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } ctrl_state_e;

   // CLEAR and LOAD complete in one register cycle; the command's count field is ignored.
   function automatic logic is_single_cycle(sr_op_e op);
      return (op == OP_CLEAR) || (op == OP_LOAD);
   endfunction

   function automatic logic is_arith(sr_op_e op);
      return (op == OP_ASL) || (op == OP_ASR);
   endfunction

endpackage

// File: rtl/shreg_ctrl_counter.sv
// Repeat counter for the shift-register controller: loaded with the run length,
// decremented once per RUN cycle, flags the final cycle.
module shreg_ctrl_counter #(
   parameter int CW = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          load,
   input  logic [CW-1:0] load_val,
   input  logic          dec,
   output logic          last
);

   logic [CW-1:0] count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (dec && (count != '0)) begin
         count <= count - CW'(1);
      end
   end

   assign last = (count == CW'(1));

endmodule

// File: rtl/shreg_ctrl.sv
// Command sequencer for an external universal shift register (IDLE -> RUN -> DONE).
// Define SHREG_CTRL_ARITH_EN to execute ASL/ASR; otherwise they are rejected with cmd_err.
module shreg_ctrl
   import shreg_ctrl_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CW    = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [2:0]       cmd_code,
   input  logic [CW-1:0]    cmd_count,
   input  logic [WIDTH-1:0] cmd_data,
   input  logic             ser_in,
   output logic             ser_out,
   output logic             ser_out_valid,
   output logic [2:0]       sr_op,
   output logic             sr_shift_in,
   output logic [WIDTH-1:0] sr_din,
   input  logic [WIDTH-1:0] sr_dout,
   output logic             done,
   output logic             cmd_err
);

`ifdef SHREG_CTRL_ARITH_EN
   localparam bit ARITH_EN = 1'b1;
`else
   localparam bit ARITH_EN = 1'b0;
`endif

   localparam logic [CW-1:0] WIDTH_CW = CW'(WIDTH);

   ctrl_state_e      state;
   ctrl_state_e      next_state;
   sr_op_e           code_q;
   logic [WIDTH-1:0] data_q;
   logic             err_q;

   sr_op_e           cmd_op;
   logic             accept;
   logic             reject;
   logic [CW-1:0]    count_clamped;
   logic [CW-1:0]    run_len;
   logic             run_last;

   assign cmd_op        = sr_op_e'(cmd_code);
   assign accept        = cmd_valid && (state == ST_IDLE);
   assign reject        = !ARITH_EN && is_arith(cmd_op);
   assign count_clamped = (cmd_count > WIDTH_CW) ? WIDTH_CW : cmd_count;
   assign run_len       = is_single_cycle(cmd_op) ? CW'(1) : count_clamped;

   shreg_ctrl_counter #(
      .CW(CW)
   ) u_counter (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (accept),
      .load_val (run_len),
      .dec      (state == ST_RUN),
      .last     (run_last)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // A zero-length shift/rotate goes straight to DONE; a rejected code never leaves IDLE.
   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE: begin
            if (accept && !reject) begin
               next_state = (run_len == '0) ? ST_DONE : ST_RUN;
            end
         end
         ST_RUN: begin
            if (run_last) begin
               next_state = ST_DONE;
            end
         end
         ST_DONE: next_state = ST_IDLE;
         default: next_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         code_q <= OP_CLEAR;
         data_q <= '0;
         err_q  <= 1'b0;
      end else begin
         err_q <= accept && reject;
         if (accept) begin
            code_q <= cmd_op;
            data_q <= cmd_data;
         end
      end
   end

   // The register has no hold code, so outside RUN it reloads its own contents.
   always_comb begin
      cmd_ready     = 1'b0;
      done          = 1'b0;
      sr_op         = OP_LOAD;
      sr_din        = sr_dout;
      sr_shift_in   = 1'b0;
      ser_out       = 1'b0;
      ser_out_valid = 1'b0;
      case (state)
         ST_IDLE: cmd_ready = 1'b1;
         ST_RUN: begin
            sr_op       = code_q;
            sr_shift_in = ser_in;
            if (code_q == OP_LOAD) begin
               sr_din = data_q;
            end
            case (code_q)
               OP_SHL, OP_ROL: begin
                  ser_out_valid = 1'b1;
                  ser_out       = sr_dout[WIDTH-1];
               end
               OP_ASL: begin
                  ser_out_valid = 1'b1;
                  ser_out       = sr_dout[WIDTH-2];
               end
               OP_SHR, OP_ROR, OP_ASR: begin
                  ser_out_valid = 1'b1;
                  ser_out       = sr_dout[0];
               end
               default: ;
            endcase
         end
         ST_DONE: done = 1'b1;
         default: ;
      endcase
   end

   assign cmd_err = err_q;

endmodule

// File: tb/tb_shreg_ctrl.sv
// Scoreboard bench for shreg_ctrl paired with a behavioural 8-bit universal shift register.
// Expected results come from closed-form arithmetic on each command.
module tb_shreg_ctrl;
   import shreg_ctrl_pkg::*;

   localparam int WIDTH = 8;
   localparam int CW    = 4;

`ifdef SHREG_CTRL_ARITH_EN
   localparam bit ARITH_EN = 1'b1;
`else
   localparam bit ARITH_EN = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             cmd_valid = 1'b0;
   logic             cmd_ready;
   logic [2:0]       cmd_code = 3'd0;
   logic [CW-1:0]    cmd_count = '0;
   logic [WIDTH-1:0] cmd_data = '0;
   logic             ser_in = 1'b0;
   logic             ser_out;
   logic             ser_out_valid;
   logic [2:0]       sr_op;
   logic             sr_shift_in;
   logic [WIDTH-1:0] sr_din;
   logic [WIDTH-1:0] sr_dout;
   logic             done;
   logic             cmd_err;

   logic [7:0] reg_q = 8'h00;
   assign sr_dout = reg_q;

   typedef struct {
      int bit_v;
      int op;
   } ser_exp_t;

   ser_exp_t ser_q[$];
   int       done_q[$];
   int       err_q[$];
   ser_exp_t mon_e;
   int       model_value = 0;
   int       checks = 0;
   int       errors = 0;

   shreg_ctrl #(
      .WIDTH(WIDTH),
      .CW   (CW)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .cmd_code     (cmd_code),
      .cmd_count    (cmd_count),
      .cmd_data     (cmd_data),
      .ser_in       (ser_in),
      .ser_out      (ser_out),
      .ser_out_valid(ser_out_valid),
      .sr_op        (sr_op),
      .sr_shift_in  (sr_shift_in),
      .sr_din       (sr_din),
      .sr_dout      (sr_dout),
      .done         (done),
      .cmd_err      (cmd_err)
   );

   always #5 clk = ~clk;

   // Paired universal shift register (no reset; ASL keeps the sign bit, ASR sign-fills)
   always @(posedge clk) begin
      case (sr_op)
         3'b000:  reg_q <= 8'h00;
         3'b001:  reg_q <= {reg_q[6:0], sr_shift_in};
         3'b010:  reg_q <= {sr_shift_in, reg_q[7:1]};
         3'b011:  reg_q <= sr_din;
         3'b100:  reg_q <= {reg_q[6:0], reg_q[7]};
         3'b101:  reg_q <= {reg_q[0], reg_q[7:1]};
         3'b110:  reg_q <= {reg_q[7], reg_q[5:0], sr_shift_in};
         3'b111:  reg_q <= {reg_q[7], reg_q[7:1]};
         default: reg_q <= reg_q;
      endcase
   end

   // Register value after n applications of op, computed arithmetically
   function automatic int apply_op(int op, int v, int n, int data, int fill);
      int ones_low;
      int ones_high;
      ones_low  = fill ? ((1 << n) - 1) : 0;
      ones_high = 255 ^ (255 >> n);
      case (op)
         0: return 0;
         1: return ((v << n) | ones_low) & 255;
         2: return (v >> n) | (fill ? ones_high : 0);
         3: return data & 255;
         4: return ((v << n) | (v >> (8 - n))) & 255;
         5: return ((v >> n) | (v << (8 - n))) & 255;
         6: return (v & 128) | (((v << n) | ones_low) & 127);
         default: return ((v & 128) != 0) ? ((v >> n) | ones_high) : (v >> n);
      endcase
   endfunction

   function automatic int leaving_bit(int op, int v);
      if (op == 1 || op == 4) return (v >> 7) & 1;
      if (op == 6) return (v >> 6) & 1;
      return v & 1;
   endfunction

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic wait_ready(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (cmd_ready === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) checkOutput("ready_timeout", 0, 1);
   endtask

   task automatic applyStimulus(input int code, input int count, input int data,
                                input bit fill, input bit hold_valid);
      int n;
      int lat;
      int tmp;
      bit rej;
      bit ok;
      wait_ready(ok);
      if (!ok) return;
      rej = (code >= 6) && !ARITH_EN;
      n   = (code == 0 || code == 3) ? 1 : ((count > 8) ? 8 : count);
      cmd_valid = 1'b1;
      cmd_code  = 3'(code);
      cmd_count = CW'(count);
      cmd_data  = 8'(data);
      ser_in    = fill;
      if (rej) begin
         err_q.push_back(model_value);
      end else begin
         if (code != 0 && code != 3) begin
            for (int i = 0; i < n; i++) begin
               tmp = apply_op(code, model_value, i, data, fill);
               ser_q.push_back('{bit_v: leaving_bit(code, tmp), op: code});
            end
         end
         model_value = apply_op(code, model_value, n, data, fill);
         done_q.push_back(model_value);
      end
      @(posedge clk);
      #1;
      if (hold_valid) begin
         cmd_code = 3'b000;
         cmd_data = 8'h00;
      end else begin
         cmd_valid = 1'b0;
      end
      lat = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (i == 0 && !rej && (code == 0 || code == 3)) begin
            checkOutput("single_op", int'(sr_op), code);
            if (code == 3) checkOutput("load_din", int'(sr_din), data & 255);
         end
         if (cmd_ready === 1'b1) break;
         lat++;
      end
      cmd_valid = 1'b0;
      checkOutput("latency", lat, rej ? 0 : n + 1);
   endtask

   // Monitor: pops an expectation whenever the DUT presents a serial bit, done or cmd_err
   always @(negedge clk) begin
      if (ser_out_valid === 1'b1) begin
         if (ser_q.size() == 0) begin
            checkOutput("ser_unexpected", 1, 0);
         end else begin
            mon_e = ser_q.pop_front();
            checkOutput("ser_out", int'(ser_out), mon_e.bit_v);
            checkOutput("run_op", int'(sr_op), mon_e.op);
         end
      end
      if (done === 1'b1) begin
         if (done_q.size() == 0) checkOutput("done_unexpected", 1, 0);
         else checkOutput("done_value", int'(sr_dout), done_q.pop_front());
      end
      if (cmd_err === 1'b1) begin
         if (err_q.size() == 0) checkOutput("err_unexpected", 1, 0);
         else checkOutput("err_value", int'(sr_dout), err_q.pop_front());
      end
      if (cmd_ready === 1'b1 || done === 1'b1) begin
         checkOutput("hold_op", int'(sr_op), 3);
         checkOutput("hold_din", int'(sr_din), int'(sr_dout));
         checkOutput("idle_ser", int'({ser_out_valid, ser_out}), 0);
         checkOutput("idle_shift_in", int'(sr_shift_in), 0);
      end
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int code;
      int count;
      int data;
      bit fill;
      bit hold;
      bit ok;

      ser_in = 1'b1;
      #1;
      checkOutput("rst_ready", int'(cmd_ready), 1);
      checkOutput("rst_done", int'(done), 0);
      checkOutput("rst_err", int'(cmd_err), 0);
      checkOutput("rst_ser", int'({ser_out_valid, ser_out}), 0);
      checkOutput("rst_op", int'(sr_op), 3);
      checkOutput("rst_shift_in", int'(sr_shift_in), 0);
      checkOutput("rst_din", int'(sr_din), int'(sr_dout));
      ser_in = 1'b0;
      #21;
      rst_n = 1'b1;
      model_value = 0;

      applyStimulus(3, 0, 'hA5, 1'b0, 1'b0);
      repeat (10) begin
         @(negedge clk);
         checkOutput("load_hold", int'(sr_dout), 'hA5);
      end
      applyStimulus(4, 3, 0, 1'b0, 1'b0);
      checkOutput("rol_result", int'(sr_dout), 'h2D);

      applyStimulus(3, 0, 'h81, 1'b0, 1'b0);
      applyStimulus(2, 12, 0, 1'b1, 1'b0);
      checkOutput("shr_clamp_result", int'(sr_dout), 'hFF);

      applyStimulus(1, 0, 0, 1'b0, 1'b0);
      checkOutput("shl_zero_result", int'(sr_dout), 'hFF);
      applyStimulus(1, 3, 0, 1'b0, 1'b1);
      checkOutput("held_valid_result", int'(sr_dout), 'hF8);

      // Reset during the third RUN cycle of SHL count=5
      applyStimulus(3, 0, 'h5A, 1'b0, 1'b0);
      wait_ready(ok);
      cmd_valid = 1'b1;
      cmd_code  = 3'd1;
      cmd_count = CW'(5);
      ser_in    = 1'b1;
      for (int i = 0; i < 2; i++) begin
         ser_q.push_back('{bit_v: leaving_bit(1, apply_op(1, model_value, i, 0, 1)), op: 1});
      end
      model_value = apply_op(1, model_value, 2, 0, 1);
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("midrun_rst_ready", int'(cmd_ready), 1);
      checkOutput("midrun_rst_op", int'(sr_op), 3);
      checkOutput("midrun_rst_done", int'(done), 0);
      checkOutput("midrun_rst_ser", int'(ser_out_valid), 0);
      repeat (2) @(posedge clk);
      #3;
      rst_n = 1'b1;
      ser_in = 1'b0;
      checkOutput("midrun_rst_value", int'(sr_dout), 'h6B);
      applyStimulus(3, 0, 'h3C, 1'b0, 1'b0);
      checkOutput("post_rst_load", int'(sr_dout), 'h3C);

      applyStimulus(3, 0, 'h80, 1'b0, 1'b0);
      applyStimulus(7, 2, 0, 1'b0, 1'b0);
      checkOutput("asr_result", int'(sr_dout), ARITH_EN ? 'hE0 : 'h80);

      repeat (60) begin
         code  = int'($urandom_range(0, 7));
         count = int'($urandom_range(0, 15));
         data  = int'($urandom_range(0, 255));
         fill  = 1'($urandom_range(0, 1));
         hold  = ($urandom_range(0, 3) == 0);
         applyStimulus(code, count, data, fill, hold);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      repeat (5) @(negedge clk);
      checkOutput("ser_q_drained", ser_q.size(), 0);
      checkOutput("done_q_drained", done_q.size(), 0);
      checkOutput("err_q_drained", err_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/shreg_ctrl.md
SHREG_CTRL -- requirements
Module: shreg_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, register width in bits (>=4).
REQ-002 SHALL have parameter CW, default $clog2(WIDTH+1), width of the count field.
REQ-003 SHALL have ports: clk  in  1  single clock, rising edge.
REQ-004 SHALL have ports: rst_n  in  1  asynchronous, active-low reset.
REQ-005 SHALL have ports: cmd_valid in 1, cmd_ready out 1, cmd_code in 3 (operation), cmd_count in CW (repeat count), cmd_data in WIDTH (load value).
REQ-006 SHALL have ports: ser_in in 1 (serial fill bit), ser_out out 1, ser_out_valid out 1 (bit leaving register).
REQ-007 SHALL have ports: sr_op out 3, sr_shift_in out 1, sr_din out WIDTH (drive the shift register), sr_dout in WIDTH (register contents).
REQ-008 SHALL have ports: done out 1 (completion pulse), cmd_err out 1 (rejection pulse).

Function
REQ-009 SHALL use operation codes 000 CLEAR, 001 SHL, 010 SHR, 011 LOAD, 100 ROL, 101 ROR, 110 ASL, 111 ASR; these are driven on sr_op unchanged.
REQ-010 SHALL implement FSM IDLE -> RUN -> DONE -> IDLE; cmd_ready=1 only in IDLE.
REQ-011 SHALL accept a command on cmd_valid&&cmd_ready; cmd_code, cmd_count, cmd_data registered at acceptance.
REQ-012 SHALL hold the register outside RUN by driving sr_op=011 and sr_din=sr_dout (the register has no hold code).
REQ-013 SHALL, in RUN, drive sr_op=captured code for N consecutive cycles, then enter DONE.
REQ-014 SHALL set N=1 for CLEAR and LOAD regardless of cmd_count; otherwise N=cmd_count, clamped to WIDTH when cmd_count>WIDTH.
REQ-015 SHALL treat cmd_count=0 for shift/rotate as no-op: IDLE -> DONE directly, zero RUN cycles, register held.
REQ-016 SHALL drive sr_din=captured cmd_data during a LOAD RUN cycle.
REQ-017 SHALL drive sr_shift_in=ser_in combinationally during RUN, 0 otherwise.
REQ-018 SHALL drive ser_out_valid=1 in each RUN cycle of SHL/ASL/ROL/SHR/ASR/ROR, ser_out=sr_dout[WIDTH-1] for left ops, sr_dout[WIDTH-2] for ASL, sr_dout[0] for right ops; ser_out_valid=0, ser_out=0 otherwise.
REQ-019 SHALL pulse done for exactly the one DONE cycle; sr_dout then reflects the final result.
REQ-020 SHALL ignore cmd_valid outside IDLE; no queuing; command latency = N+2 cycles from acceptance to next cmd_ready.
REQ-021 SHALL keep cmd_err=0 and never reject a code except per REQ-026.

Reset
REQ-022 SHALL, on rst_n low, asynchronously enter IDLE, clear counter and captured fields to 0.
REQ-023 SHALL reset outputs: cmd_ready=1, done=0, cmd_err=0, ser_out=0, ser_out_valid=0, sr_op=011, sr_shift_in=0, sr_din=sr_dout.
REQ-024 SHALL, on reset mid-RUN, abandon the command without done; first acceptance possible in the first cycle after rst_n rises.

Configuration
REQ-025 SHALL, with SHREG_CTRL_ARITH_EN defined, accept ASL/ASR like other shifts.
REQ-026 SHALL, without SHREG_CTRL_ARITH_EN, accept 110/111 but skip RUN and DONE: one-cycle cmd_err pulse in the cycle after acceptance, FSM stays IDLE, register held, no done.

Structure
REQ-027 SHALL place operation-code and FSM-state enums in package shreg_ctrl_pkg, shared with the shift register bench.
REQ-028 SHALL implement the repeat counter (load N, decrement, last flag) as sub-module shreg_ctrl_counter.

Verification (WIDTH=8, paired with an 8-bit universal shift register)
REQ-029 SHALL cover: LOAD 0xA5 -> sr_op=011 with sr_din=0xA5 one cycle, done next cycle, sr_dout=0xA5 held 10 idle cycles.
REQ-030 SHALL cover: from 0xA5, ROL count=3 -> three sr_op=100 cycles, ser_out 1,0,1, sr_dout=0x2D, done once.
REQ-031 SHALL cover: from 0x81, SHR count=12, ser_in=1 -> clamped to 8 cycles, sr_dout=0xFF, ser_out 1,0,0,0,0,0,0,1.
REQ-032 SHALL cover: SHL count=0 -> done in cycle after acceptance, no RUN, sr_dout unchanged; cmd_valid held during RUN of another command is not accepted.
REQ-033 SHALL cover: rst_n low during 3rd cycle of SHL count=5 -> immediate IDLE, sr_op=011, no done, new LOAD 0x3C accepted after release.
REQ-034 SHALL cover: ASR from 0x80, count=2, both macro settings -> with macro done and sr_dout per register semantics; without, single cmd_err, no done, sr_dout=0x80.
